// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory port.
package lsu_pkg;

  localparam int unsigned DEFAULT_XLEN    = 64;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // An access is misaligned when its low address bits are not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] lane, input size_e size);
    logic mis;
    unique case (size)
      SZ_B: mis = 1'b0;
      SZ_H: mis = lane[0];
      SZ_W: mis = |lane[1:0];
      SZ_D: mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core request/response and memory-responder signals of the LSU port.
// slave is the LSU's view; master is the environment (core plus memory responder).
interface lsu_mem_port_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_load;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_re;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Pure combinational lane logic: store byte-enable/shift and load shift/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  size_e           st_size,
  input  logic [2:0]      st_lane,
  input  logic [XLEN-1:0] st_wdata,
  output logic [7:0]      st_mask,
  output logic [XLEN-1:0] st_data,
  input  size_e           ld_size,
  input  logic [2:0]      ld_lane,
  input  logic            ld_unsigned,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]      base_mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    base_mask = 8'h00;
    ld_data   = '0;
    unique case (st_size)
      SZ_B: base_mask = 8'h01;
      SZ_H: base_mask = 8'h03;
      SZ_W: base_mask = 8'h0f;
      SZ_D: base_mask = 8'hff;
    endcase
    st_mask = base_mask << st_lane;
    st_data = st_wdata << {st_lane, 3'b000};

    shifted = ld_rdata >> {ld_lane, 3'b000};
    // Doubleword loads fill the whole register, so signedness does not apply.
    unique case (ld_size)
      SZ_B: ld_data = ld_unsigned ? XLEN'(shifted[7:0])
                                  : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ld_data = ld_unsigned ? XLEN'(shifted[15:0])
                                  : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W: ld_data = ld_unsigned ? XLEN'(shifted[31:0])
                                  : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      SZ_D: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding LSU memory port: accept, issue strobe, await data, respond.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e          state;
  logic [CNT_W-1:0] cnt;
  size_e           size_q;
  logic [2:0]      lane_q;
  logic            unsigned_q;
  logic            load_q;

  size_e           req_size_e;
  logic [7:0]      st_mask;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] ld_data;
  logic            timeout_hit;
  logic            req_mis;

  assign req_size_e    = size_e'(bus.req_size);
  assign req_mis       = is_misaligned(bus.req_addr[2:0], req_size_e);
  assign bus.req_ready = (state == ST_IDLE);
  // The counter equals the ISSUE+WAIT cycles already spent; this is the last allowed one.
  assign timeout_hit   = (cnt == CNT_W'(TIMEOUT - 1));

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size     (req_size_e),
    .st_lane     (bus.req_addr[2:0]),
    .st_wdata    (bus.req_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (size_q),
    .ld_lane     (lane_q),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (bus.mem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      size_q         <= SZ_B;
      lane_q         <= 3'd0;
      unsigned_q     <= 1'b0;
      load_q         <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wmask  <= 8'h00;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            size_q     <= req_size_e;
            lane_q     <= bus.req_addr[2:0];
            unsigned_q <= bus.req_unsigned;
            load_q     <= bus.req_load;
            if (req_mis) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              state         <= ST_ISSUE;
              cnt           <= '0;
              bus.mem_re    <= bus.req_load;
              bus.mem_we    <= ~bus.req_load;
              bus.mem_addr  <= {bus.req_addr[XLEN-1:3], 3'b000};
              bus.mem_wdata <= st_data;
              bus.mem_wmask <= st_mask;
            end
          end
        end
        ST_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit || bus.mem_ready) begin
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wmask <= 8'h00;
          end
          if (timeout_hit) begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else if (bus.mem_ready) begin
            if (load_q) begin
              state <= ST_WAIT;
            end else begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else if (bus.mem_rvalid) begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= ld_data;
          end
        end
        ST_RESP: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed and randomized checks of lsu_mem_port against a byte-level reference model.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  lsu_mem_port_if #(.XLEN(XLEN)) bus ();

  lsu_mem_port #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: pick 2^size bytes starting at byte lane, then extend by signedness.
  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [63:0] addr,
                                             input int size, input bit uns);
    int nbytes;
    int lane;
    logic [127:0] v;
    logic [127:0] m;
    nbytes = 1 << size;
    lane   = int'(addr % 64'd8);
    v = {64'd0, rd} >> (8 * lane);
    m = (128'd1 << (8 * nbytes)) - 128'd1;
    v = v & m;
    if (!uns && size != 3 && v[8*nbytes-1]) v = v | ~m;
    return v[63:0];
  endfunction

  function automatic logic [7:0] model_mask(input logic [63:0] addr, input int size);
    logic [15:0] mm;
    mm = ((16'd1 << (1 << size)) - 16'd1) << int'(addr % 64'd8);
    return mm[7:0];
  endfunction

  function automatic bit model_mis(input logic [63:0] addr, input int size);
    return (addr % (64'd1 << size)) != 64'd0;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_req(input bit ld, input int sz, input bit uns,
                           input logic [63:0] addr, input logic [63:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_load     = ld;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // One complete op; all driving and sampling happens at the falling edge.
  task automatic do_op(input string tag, input bit ld, input int sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int rdly, input int vdly);
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'd7;
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    drive_req(ld, sz, uns, addr, wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (model_mis(addr, sz)) begin
      check({tag, " mis resp_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, " mis resp_err"}, 64'(bus.resp_err), 64'd1);
      check({tag, " mis strobes"}, {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
      @(negedge clk);
      check({tag, " mis after"}, {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
      return;
    end
    for (int d = 0; d <= rdly; d++) begin
      check({tag, " strobes"}, {62'd0, bus.mem_re, bus.mem_we}, {62'd0, ld, !ld});
      check({tag, " mem_addr"}, bus.mem_addr, exp_addr);
      check({tag, " resp quiet"}, 64'(bus.resp_valid), 64'd0);
      if (!ld) begin
        check({tag, " mem_wmask"}, 64'(bus.mem_wmask), 64'(model_mask(addr, sz)));
        check({tag, " mem_wdata"}, bus.mem_wdata, wdata << (8 * int'(addr % 64'd8)));
      end
      bus.mem_ready  = (d == rdly);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rand64();
      @(negedge clk);
    end
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (ld) begin
      for (int d = 0; d <= vdly; d++) begin
        check({tag, " wait strobes"}, {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
        check({tag, " wait resp"}, 64'(bus.resp_valid), 64'd0);
        bus.mem_rvalid = (d == vdly);
        bus.mem_rdata  = (d == vdly) ? rdata : rand64();
        @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
    end
    check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd1);
    check({tag, " resp_err"}, 64'(bus.resp_err), 64'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata, ld ? model_load(rdata, addr, sz, uns) : 64'd0);
    check({tag, " resp strobes"}, {54'd0, bus.mem_wmask, bus.mem_re, bus.mem_we}, 64'd0);
    @(negedge clk);
    check({tag, " resp one-shot"}, {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset flags", {58'd0, bus.resp_valid, bus.resp_err, bus.mem_re, bus.mem_we, 2'b00}, 64'd0);
    check("reset ready", 64'(bus.req_ready), 64'd1);
    check("reset rdata", bus.resp_rdata, 64'd0);
    check("reset mem_addr", bus.mem_addr, 64'd0);
    check("reset mem_wdata", bus.mem_wdata, 64'd0);
    check("reset mem_wmask", 64'(bus.mem_wmask), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("sb", 1'b0, 0, 1'b0, 64'h8000_0003, 64'hAB, 64'd0, 0, 0);
    do_op("lh", 1'b1, 1, 1'b0, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
    do_op("lhu", 1'b1, 1, 1'b1, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 1, 2);
    do_op("lw mis", 1'b1, 2, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 0, 0);
    do_op("ld", 1'b1, 3, 1'b1, 64'h8000_0010, 64'd0, 64'hF123_4567_89AB_CDEF, 2, 1);

    // Responder never accepts: the op must time out after TIMEOUT cycles in ISSUE.
    drive_req(1'b1, 2, 1'b0, 64'h8000_0020, 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      check("timeout re held", {62'd0, bus.mem_re, bus.resp_valid}, 64'd2);
      @(negedge clk);
    end
    check("timeout resp", {61'd0, bus.resp_valid, bus.resp_err, bus.mem_re}, 64'd6);
    check("timeout rdata", bus.resp_rdata, 64'd0);
    @(negedge clk);
    check("timeout ready", {62'd0, bus.req_ready, bus.mem_re}, 64'd2);

    // Reset while waiting for read data aborts the op silently.
    drive_req(1'b1, 3, 1'b0, 64'h8000_0040, 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    rst = 1'b0;
    check("rst abort", {61'd0, bus.resp_valid, bus.mem_re, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("rst no late resp", 64'(bus.resp_valid), 64'd0);
    do_op("ld after rst", 1'b1, 3, 1'b0, 64'h8000_0048, 64'd0, 64'h8765_4321_0FED_CBA9, 0, 0);

    // Back-to-back: second op waits until the cycle after the first response.
    drive_req(1'b0, 0, 1'b0, 64'h100, 64'h11);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("b2b first resp", {62'd0, bus.resp_valid, bus.req_ready}, 64'd2);
    a = 64'h208;
    drive_req(1'b0, 3, 1'b0, a, 64'hDEAD_BEEF_0BAD_F00D);
    @(negedge clk);
    check("b2b idle gap", {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b second issue", {62'd0, bus.mem_we, bus.req_ready}, 64'd2);
    check("b2b second addr", bus.mem_addr, a);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("b2b second resp", {62'd0, bus.resp_valid, bus.resp_err}, 64'd2);
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      bit ld;
      int sz;
      ld = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 3));
      a  = rand64();
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_op($sformatf("rand%0d", n), ld, sz, 1'($urandom_range(0, 1)), a, rand64(), rand64(),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, giving the maximum cycles spent in ISSUE+WAIT before an error response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: the core presents a memory op.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts an op, high only in IDLE.
REQ-007 SHALL have port req_load, input, 1 bit: 1 = load, 0 = store.
REQ-008 SHALL have port req_size, input, 2 bits: access size, 0=B, 1=H, 2=W, 3=D.
REQ-009 SHALL have port req_unsigned, input, 1 bit: zero-extend the load result.
REQ-010 SHALL have ports req_addr and req_wdata, input, XLEN bits each: byte address and store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, XLEN bits: extended load data, 0 for stores.
REQ-013 SHALL have port resp_err, output, 1 bit: misaligned access or timeout.
REQ-014 SHALL have ports mem_re and mem_we, output, 1 bit each: read and write strobes to the memory responder.
REQ-015 SHALL have port mem_addr, output, XLEN bits: 8-byte-aligned address (req_addr with bits [2:0] cleared).
REQ-016 SHALL have ports mem_wdata, output, XLEN bits, and mem_wmask, output, 8 bits: lane-shifted store data and byte enables.
REQ-017 SHALL have port mem_ready, input, 1 bit: the responder accepts the strobe this cycle.
REQ-018 SHALL have ports mem_rvalid, input, 1 bit, and mem_rdata, input, XLEN bits: read data return.

Function
REQ-019 SHALL implement the FSM IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: on req_valid, the block SHALL latch all req_* fields. A misaligned op (req_addr mod 2^size != 0) SHALL go to RESP with err=1 and SHALL not drive any memory strobe. Otherwise the FSM SHALL go to ISSUE.
REQ-021 ISSUE: the block SHALL assert exactly one of mem_re or mem_we and SHALL hold it and all mem_* outputs stable until mem_ready=1. On that handshake, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-022 WAIT: on mem_rvalid, the block SHALL capture mem_rdata and go to RESP. mem_rvalid SHALL be ignored in every other state, including the handshake cycle in ISSUE.
REQ-023 RESP: resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. There is no response backpressure.
REQ-024 Lane and mask: lane = addr[2:0]; mem_wmask = ((1<<2^size)-1) << lane; mem_wdata = req_wdata << 8*lane.
REQ-025 Load result: (mem_rdata >> 8*lane) truncated to 2^size bytes, then sign-extended, or zero-extended when req_unsigned=1. For size=3, req_unsigned SHALL be ignored.
REQ-026 Timeout: a counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT. When it reaches TIMEOUT, the FSM SHALL go to RESP with err=1 and resp_rdata=0, and the strobes SHALL drop on the same edge.
REQ-027 Latency: with accept at edge T and mem_ready=1 immediately, the strobe SHALL be high in T+1, a store SHALL assert resp_valid in T+2, and a load SHALL assert resp_valid the cycle after mem_rvalid.
REQ-028 Strobes and mem_wmask SHALL be 0 outside ISSUE.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and the counter to 0. resp_valid, resp_err, mem_re and mem_we SHALL be 0, and resp_rdata, mem_addr, mem_wdata and mem_wmask SHALL be 0.
REQ-030 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abort with no resp_valid. Strobes SHALL be low and req_ready=1 in the cycle after rst deasserts.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, the size encodings (SZ_B/H/W/D) and the default TIMEOUT.
REQ-032 Sub-module lsu_align SHALL be pure combinational: mask generation, store shift, and load shift/extend.

Verification
REQ-033 Store byte: SB 0xAB @0x8000_0003 -> mem_addr 0x8000_0000, mem_wmask 0x08, mem_wdata[31:24]=0xAB; resp_valid, err=0, one cycle after mem_ready.
REQ-034 Load half: LH @0x8000_0006 with mem_rdata 0x8001_0000_0000_0000 -> 0xFFFF_FFFF_FFFF_8001; the same access as LHU -> 0x0000_0000_0000_8001.
REQ-035 Misaligned: LW @0x8000_0002 -> resp_valid with err=1 at T+1; mem_re never high.
REQ-036 Timeout: mem_ready held 0 for 1023 cycles -> resp_err=1, mem_re low afterward, req_ready=1 next cycle.
REQ-037 Reset in WAIT: rst for one cycle -> no resp_valid; a new LD is accepted and completes normally.
REQ-038 Back-to-back: req_valid held for two ops -> the second is accepted only in the cycle after the first resp_valid.
